reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Circular in-order reorder buffer between Decoder/RS/LSB and RegFile. Allocates one entry per issued
//  instruction, captures ALU/LSB results, retires head in order: register writes go to RegFile commit port,
//  stores are released to LSB, branch mispredicts raise rollback and redirect fetch.
// PARAMETERS
//  ROB_SIZE  16  entries (power of two)
//  ROB_W     4   log2(ROB_SIZE), pointer width
//  DATA_W    32  result/PC width
//  REG_W     5   architectural register index width
// PORTS
//  clk            in   1       clock
//  rst            in   1       reset, asynchronous, active-high
//  rdy            in   1       global enable; low = hold all state
//  issue          in   1       allocate entry at tail
//  issue_type     in   2       0 REG, 1 BRANCH, 2 STORE, 3 EXIT
//  issue_rd       in   REG_W   destination register (REG only)
//  issue_pc       in   DATA_W  instruction PC
//  issue_pred_jmp in   1       predictor decision (BRANCH)
//  issue_ready    in   1       result known at issue (LUI/AUIPC/JAL)
//  issue_val      in   DATA_W  result when issue_ready
//  issue_rob_pos  out  ROB_W   current tail; tag given to RegFile/RS
//  full           out  1       count >= ROB_SIZE-1
//  alu_valid      in   1       ALU broadcast
//  alu_rob_pos    in   ROB_W   / alu_val DATA_W / alu_jmp 1 / alu_target DATA_W
//  lsb_valid      in   1       LSB broadcast; lsb_rob_pos ROB_W, lsb_val DATA_W
//  q1_pos,q2_pos  in   ROB_W   operand query tags from Decoder
//  q1_ready,q2_ready out 1     queried entry ready
//  q1_val,q2_val  out  DATA_W  queried entry value
//  commit         out  1       registered pulse: retire REG entry to RegFile
//  commit_rd      out  REG_W   / commit_val DATA_W / commit_rob_pos ROB_W
//  store_commit   out  1       pulse: LSB may perform store at store_rob_pos (ROB_W)
//  rollback       out  1       registered one-cycle pulse on mispredict
//  redirect_pc    out  DATA_W  fetch target, valid with rollback
//  halt           out  1       EXIT retired; sticky until reset
// BEHAVIOUR
//  - Reset: head=tail=count=0, all busy/ready clear; every output 0.
//  - Issue (rdy & issue & !full): entry[tail] <= {busy,type,rd,pc,pred,ready=issue_ready,val}; tail+1 mod SIZE.
//    Decoder must not issue when full; full leaves one slot margin for the registered decode.
//  - Writeback: alu_valid / lsb_valid set ready,val (ALU also jmp,target) at given pos; both same cycle
//    to different pos both land; writes to non-busy entries ignored.
//  - Commit: at most one per cycle when busy[head]&ready[head]; outputs registered, 1 cycle after ready seen.
//    REG: commit=1 (rd==0 still pulses; RegFile drops it). STORE: store_commit=1. EXIT: halt=1, no more commits.
//    BRANCH: jmp!=pred -> rollback=1, redirect_pc = jmp ? target : pc+4; else no output pulse.
//  - Commit+issue same cycle: both proceed, count unchanged; full with simultaneous commit frees a slot next cycle.
//  - Rollback cycle: all entries invalidated, head=tail=count=0; issue and writebacks that cycle discarded.
//  - Queries combinational: q*_ready/val = entry[q*_pos]; tail wrap modulo ROB_SIZE, no empty/full ambiguity (count).
//  - rdy low: no state change, pulse outputs forced 0. Async rst mid-operation: immediate clear, no pulse emitted.
// CONFIGURATION
//  ROB_CDB_FWD_EN defined: q*_ready/val also forward this-cycle alu/lsb broadcast whose pos matches q*_pos
//  (ALU priority if both). Undefined: queries see only stored state; match resolves one cycle later.
// STRUCTURE
//  Shared def package: ROB_SIZE/ROB_W/DATA_W/REG_W, ROB type encodings, entry field widths.
//  One natural sub-module: rob_query_port (instanced twice) for combinational lookup + optional forwarding.
// TESTING
//  - Issue REG rd=5 pos0, ALU pos0 val=0x1234 -> next cycle commit=1, commit_rd=5, commit_val=0x1234, rob_pos=0.
//  - Issue 15 entries none ready -> full=1 after 15th; commit head -> full=0 next cycle; tail wraps 15->0.
//  - Branch pc=0x100 pred=0, ALU jmp=1 target=0x200 -> rollback=1, redirect_pc=0x200 for one cycle; count=0 after.
//  - Results out of order pos2,pos1,pos0 -> commits strictly pos0,pos1,pos2 on consecutive cycles.
//  - Query pos3 while ALU broadcasts pos3 val=7 -> q1_ready=1,q1_val=7 same cycle with ROB_CDB_FWD_EN, 0 without.
//  - Assert rst with 4 entries busy, rdy low toggled -> all outputs 0 immediately; issue after release gets pos0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: sizes, entry type encodings and entry layout.
package reorder_buffer_pkg;

  localparam int unsigned ROB_SIZE = 16;
  localparam int unsigned ROB_W    = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_W    = 5;

  localparam logic [ROB_W:0] FULL_THRESH = (ROB_W + 1)'(ROB_SIZE - 1);

  typedef enum logic [1:0] {
    RobReg    = 2'd0,
    RobBranch = 2'd1,
    RobStore  = 2'd2,
    RobExit   = 2'd3
  } rob_type_e;

  typedef struct packed {
    logic              busy;
    logic              ready;
    rob_type_e         rtype;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] pc;
    logic              pred;
    logic              jmp;
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] target;
  } rob_entry_t;

  function automatic logic [DATA_W-1:0] redirect_target(input rob_entry_t e);
    return e.jmp ? e.target : e.pc + DATA_W'(4);
  endfunction

endpackage

// File: rtl/rob_query_port.sv
// Combinational operand lookup into the ROB; ROB_CDB_FWD_EN adds same-cycle ALU/LSB forwarding.
module rob_query_port
  import reorder_buffer_pkg::*;
(
  input  logic [ROB_W-1:0]                 pos_i,
  input  logic [ROB_SIZE-1:0]              ready_i,
  input  logic [ROB_SIZE-1:0][DATA_W-1:0]  val_i,
  input  logic                             alu_valid_i,
  input  logic [ROB_W-1:0]                 alu_pos_i,
  input  logic [DATA_W-1:0]                alu_val_i,
  input  logic                             lsb_valid_i,
  input  logic [ROB_W-1:0]                 lsb_pos_i,
  input  logic [DATA_W-1:0]                lsb_val_i,
  output logic                             ready_o,
  output logic [DATA_W-1:0]                val_o
);

`ifdef ROB_CDB_FWD_EN
  // ALU wins when both broadcasts hit the queried tag.
  always_comb begin
    ready_o = ready_i[pos_i];
    val_o   = val_i[pos_i];
    if (alu_valid_i && (alu_pos_i == pos_i)) begin
      ready_o = 1'b1;
      val_o   = alu_val_i;
    end else if (lsb_valid_i && (lsb_pos_i == pos_i)) begin
      ready_o = 1'b1;
      val_o   = lsb_val_i;
    end
  end
`else
  assign ready_o = ready_i[pos_i];
  assign val_o   = val_i[pos_i];

  logic unused_fwd;
  assign unused_fwd = ^{alu_valid_i, alu_pos_i, alu_val_i, lsb_valid_i, lsb_pos_i, lsb_val_i};
`endif

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at tail, capture results, retire head in order.
// Optional same-cycle query forwarding is enabled by defining ROB_CDB_FWD_EN.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              issue,
  input  logic [1:0]        issue_type,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic [DATA_W-1:0] issue_pc,
  input  logic              issue_pred_jmp,
  input  logic              issue_ready,
  input  logic [DATA_W-1:0] issue_val,
  output logic [ROB_W-1:0]  issue_rob_pos,
  output logic              full,
  input  logic              alu_valid,
  input  logic [ROB_W-1:0]  alu_rob_pos,
  input  logic [DATA_W-1:0] alu_val,
  input  logic              alu_jmp,
  input  logic [DATA_W-1:0] alu_target,
  input  logic              lsb_valid,
  input  logic [ROB_W-1:0]  lsb_rob_pos,
  input  logic [DATA_W-1:0] lsb_val,
  input  logic [ROB_W-1:0]  q1_pos,
  input  logic [ROB_W-1:0]  q2_pos,
  output logic              q1_ready,
  output logic              q2_ready,
  output logic [DATA_W-1:0] q1_val,
  output logic [DATA_W-1:0] q2_val,
  output logic              commit,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_val,
  output logic [ROB_W-1:0]  commit_rob_pos,
  output logic              store_commit,
  output logic [ROB_W-1:0]  store_rob_pos,
  output logic              rollback,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              halt
);

  rob_entry_t        entries_q [ROB_SIZE];
  rob_entry_t        entries_d [ROB_SIZE];
  logic [ROB_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [ROB_W:0]    count_q, count_d;
  logic              commit_q, commit_d, store_commit_q, store_commit_d;
  logic              rollback_q, rollback_d, halt_q, halt_d;
  logic [REG_W-1:0]  commit_rd_q, commit_rd_d;
  logic [DATA_W-1:0] commit_val_q, commit_val_d, redirect_pc_q, redirect_pc_d;
  logic [ROB_W-1:0]  commit_pos_q, commit_pos_d, store_pos_q, store_pos_d;

  rob_entry_t head_e;
  logic       do_issue, do_commit, mispredict, discard;

  assign head_e     = entries_q[head_q];
  assign full       = (count_q >= FULL_THRESH);
  assign do_commit  = rdy & ~halt_q & head_e.busy & head_e.ready;
  assign mispredict = do_commit & (head_e.rtype == RobBranch) & (head_e.jmp != head_e.pred);
  // Issue and writebacks are dropped both on the flush edge and while rollback is visible.
  assign discard    = mispredict | rollback_q;
  assign do_issue   = rdy & issue & ~full & ~discard;

  always_comb begin
    entries_d      = entries_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    halt_d         = halt_q;
    commit_d       = 1'b0;
    commit_rd_d    = '0;
    commit_val_d   = '0;
    commit_pos_d   = '0;
    store_commit_d = 1'b0;
    store_pos_d    = '0;
    rollback_d     = 1'b0;
    redirect_pc_d  = '0;

    if (rdy && !discard) begin
      if (alu_valid && entries_q[alu_rob_pos].busy) begin
        entries_d[alu_rob_pos].ready  = 1'b1;
        entries_d[alu_rob_pos].val    = alu_val;
        entries_d[alu_rob_pos].jmp    = alu_jmp;
        entries_d[alu_rob_pos].target = alu_target;
      end
      if (lsb_valid && entries_q[lsb_rob_pos].busy) begin
        entries_d[lsb_rob_pos].ready = 1'b1;
        entries_d[lsb_rob_pos].val   = lsb_val;
      end
      if (do_issue) begin
        entries_d[tail_q].busy   = 1'b1;
        entries_d[tail_q].ready  = issue_ready;
        entries_d[tail_q].rtype  = rob_type_e'(issue_type);
        entries_d[tail_q].rd     = issue_rd;
        entries_d[tail_q].pc     = issue_pc;
        entries_d[tail_q].pred   = issue_pred_jmp;
        entries_d[tail_q].jmp    = 1'b0;
        entries_d[tail_q].val    = issue_val;
        entries_d[tail_q].target = '0;
        tail_d                   = tail_q + 1'b1;
      end
    end

    if (do_commit) begin
      entries_d[head_q].busy = 1'b0;
      head_d                 = head_q + 1'b1;
      unique case (head_e.rtype)
        RobReg: begin
          commit_d     = 1'b1;
          commit_rd_d  = head_e.rd;
          commit_val_d = head_e.val;
          commit_pos_d = head_q;
        end
        RobStore: begin
          store_commit_d = 1'b1;
          store_pos_d    = head_q;
        end
        RobExit:   halt_d = 1'b1;
        RobBranch: begin
          rollback_d    = mispredict;
          redirect_pc_d = mispredict ? redirect_target(head_e) : '0;
        end
      endcase
    end

    count_d = count_q + (ROB_W + 1)'(do_issue) - (ROB_W + 1)'(do_commit);

    if (mispredict) begin
      for (int i = 0; i < ROB_SIZE; i++) entries_d[i] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) entries_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      halt_q         <= 1'b0;
      commit_q       <= 1'b0;
      commit_rd_q    <= '0;
      commit_val_q   <= '0;
      commit_pos_q   <= '0;
      store_commit_q <= 1'b0;
      store_pos_q    <= '0;
      rollback_q     <= 1'b0;
      redirect_pc_q  <= '0;
    end else begin
      entries_q      <= entries_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      halt_q         <= halt_d;
      commit_q       <= commit_d;
      commit_rd_q    <= commit_rd_d;
      commit_val_q   <= commit_val_d;
      commit_pos_q   <= commit_pos_d;
      store_commit_q <= store_commit_d;
      store_pos_q    <= store_pos_d;
      rollback_q     <= rollback_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

  assign issue_rob_pos  = tail_q;
  assign commit         = commit_q;
  assign commit_rd      = commit_rd_q;
  assign commit_val     = commit_val_q;
  assign commit_rob_pos = commit_pos_q;
  assign store_commit   = store_commit_q;
  assign store_rob_pos  = store_pos_q;
  assign rollback       = rollback_q;
  assign redirect_pc    = redirect_pc_q;
  assign halt           = halt_q;

  logic [ROB_SIZE-1:0]             ready_vec;
  logic [ROB_SIZE-1:0][DATA_W-1:0] val_vec;

  always_comb begin
    ready_vec = '0;
    val_vec   = '0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      ready_vec[i] = entries_q[i].ready;
      val_vec[i]   = entries_q[i].val;
    end
  end

  rob_query_port u_q1 (
    .pos_i       (q1_pos),
    .ready_i     (ready_vec),
    .val_i       (val_vec),
    .alu_valid_i (alu_valid),
    .alu_pos_i   (alu_rob_pos),
    .alu_val_i   (alu_val),
    .lsb_valid_i (lsb_valid),
    .lsb_pos_i   (lsb_rob_pos),
    .lsb_val_i   (lsb_val),
    .ready_o     (q1_ready),
    .val_o       (q1_val)
  );

  rob_query_port u_q2 (
    .pos_i       (q2_pos),
    .ready_i     (ready_vec),
    .val_i       (val_vec),
    .alu_valid_i (alu_valid),
    .alu_pos_i   (alu_rob_pos),
    .alu_val_i   (alu_val),
    .lsb_valid_i (lsb_valid),
    .lsb_pos_i   (lsb_rob_pos),
    .lsb_val_i   (lsb_val),
    .ready_o     (q2_ready),
    .val_o       (q2_val)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer; each task covers one scenario.
module tb_reorder_buffer;

  logic        clk, rst, rdy;
  logic        issue, issue_pred_jmp, issue_ready;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc, issue_val;
  logic [3:0]  issue_rob_pos;
  logic        full;
  logic        alu_valid, alu_jmp, lsb_valid;
  logic [3:0]  alu_rob_pos, lsb_rob_pos, q1_pos, q2_pos;
  logic [31:0] alu_val, alu_target, lsb_val;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_val, q2_val;
  logic        commit, store_commit, rollback, halt;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val, redirect_pc;
  logic [3:0]  commit_rob_pos, store_rob_pos;

  int n_cmp;
  int n_fail;

  reorder_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .issue          (issue),
    .issue_type     (issue_type),
    .issue_rd       (issue_rd),
    .issue_pc       (issue_pc),
    .issue_pred_jmp (issue_pred_jmp),
    .issue_ready    (issue_ready),
    .issue_val      (issue_val),
    .issue_rob_pos  (issue_rob_pos),
    .full           (full),
    .alu_valid      (alu_valid),
    .alu_rob_pos    (alu_rob_pos),
    .alu_val        (alu_val),
    .alu_jmp        (alu_jmp),
    .alu_target     (alu_target),
    .lsb_valid      (lsb_valid),
    .lsb_rob_pos    (lsb_rob_pos),
    .lsb_val        (lsb_val),
    .q1_pos         (q1_pos),
    .q2_pos         (q2_pos),
    .q1_ready       (q1_ready),
    .q2_ready       (q2_ready),
    .q1_val         (q1_val),
    .q2_val         (q2_val),
    .commit         (commit),
    .commit_rd      (commit_rd),
    .commit_val     (commit_val),
    .commit_rob_pos (commit_rob_pos),
    .store_commit   (store_commit),
    .store_rob_pos  (store_rob_pos),
    .rollback       (rollback),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                           input logic pred, input logic rdy_now, input logic [31:0] val);
    issue = 1'b1; issue_type = t; issue_rd = rd; issue_pc = pc;
    issue_pred_jmp = pred; issue_ready = rdy_now; issue_val = val;
  endtask

  task automatic clr_inputs();
    issue = 1'b0; issue_type = 2'd0; issue_rd = '0; issue_pc = '0;
    issue_pred_jmp = 1'b0; issue_ready = 1'b0; issue_val = '0;
    alu_valid = 1'b0; alu_rob_pos = '0; alu_val = '0; alu_jmp = 1'b0; alu_target = '0;
    lsb_valid = 1'b0; lsb_rob_pos = '0; lsb_val = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; q1_pos = '0; q2_pos = '0;
    clr_inputs();
    #3;
    n_cmp++;
    if ({commit, store_commit, rollback, halt, full, issue_rob_pos, q1_ready, q1_val}
        !== {5'b0, 4'd0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got c=%b s=%b rb=%b h=%b f=%b pos=%0d q1r=%b q1v=%h, want all 0",
               commit, store_commit, rollback, halt, full, issue_rob_pos, q1_ready, q1_val);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_commit_reg();
    set_issue(2'd0, 5'd5, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    clr_inputs();
    n_cmp++;
    if (issue_rob_pos !== 4'd1) begin
      n_fail++; $display("FAIL issue_tail_advance: got %0d want 1", issue_rob_pos);
    end
    alu_valid = 1'b1; alu_rob_pos = 4'd0; alu_val = 32'h1234;
    tick();
    clr_inputs();
    n_cmp++;
    if (commit !== 1'b0) begin
      n_fail++; $display("FAIL commit_latency: commit=%b on writeback edge, want 0", commit);
    end
    tick();
    n_cmp++;
    if ({commit, commit_rd, commit_val, commit_rob_pos} !== {1'b1, 5'd5, 32'h1234, 4'd0}) begin
      n_fail++;
      $display("FAIL commit_reg: got c=%b rd=%0d val=%h pos=%0d want 1/5/00001234/0",
               commit, commit_rd, commit_val, commit_rob_pos);
    end
    tick();
    n_cmp++;
    if (commit !== 1'b0) begin
      n_fail++; $display("FAIL commit_pulse_width: commit=%b want 0", commit);
    end
  endtask

  // Entries 1..3 are allocated; query pos3 while the ALU broadcasts it.
  task automatic test_query_fwd();
    for (int i = 1; i <= 3; i++) begin
      set_issue(2'd0, 5'(i), 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
    end
    clr_inputs();
    q1_pos = 4'd3; q2_pos = 4'd2;
    alu_valid = 1'b1; alu_rob_pos = 4'd3; alu_val = 32'd7;
    #1;
    n_cmp++;
`ifdef ROB_CDB_FWD_EN
    if ({q1_ready, q1_val} !== {1'b1, 32'd7}) begin
      n_fail++; $display("FAIL query_same_cycle: got r=%b v=%h want 1/7", q1_ready, q1_val);
    end
`else
    if ({q1_ready, q1_val} !== {1'b0, 32'd0}) begin
      n_fail++; $display("FAIL query_same_cycle: got r=%b v=%h want 0/0", q1_ready, q1_val);
    end
`endif
    tick();
    clr_inputs();
    n_cmp++;
    if ({q1_ready, q1_val, q2_ready} !== {1'b1, 32'd7, 1'b0}) begin
      n_fail++;
      $display("FAIL query_stored: got q1r=%b q1v=%h q2r=%b want 1/7/0", q1_ready, q1_val, q2_ready);
    end
  endtask

  // pos3 already ready; pos1 (LSB) and pos2 (ALU) land together, commits still go 1,2,3.
  task automatic test_out_of_order();
    lsb_valid = 1'b1; lsb_rob_pos = 4'd1; lsb_val = 32'h11;
    alu_valid = 1'b1; alu_rob_pos = 4'd2; alu_val = 32'h22;
    tick();
    clr_inputs();
    tick();
    n_cmp++;
    if ({commit, commit_rob_pos, commit_val} !== {1'b1, 4'd1, 32'h11}) begin
      n_fail++; $display("FAIL ooo_commit0: got c=%b pos=%0d val=%h want 1/1/11",
                         commit, commit_rob_pos, commit_val);
    end
    tick();
    n_cmp++;
    if ({commit, commit_rob_pos, commit_val} !== {1'b1, 4'd2, 32'h22}) begin
      n_fail++; $display("FAIL ooo_commit1: got c=%b pos=%0d val=%h want 1/2/22",
                         commit, commit_rob_pos, commit_val);
    end
    tick();
    n_cmp++;
    if ({commit, commit_rob_pos, commit_val, commit_rd} !== {1'b1, 4'd3, 32'd7, 5'd3}) begin
      n_fail++; $display("FAIL ooo_commit2: got c=%b pos=%0d val=%h rd=%0d want 1/3/7/3",
                         commit, commit_rob_pos, commit_val, commit_rd);
    end
    tick();
    n_cmp++;
    if (commit !== 1'b0) begin
      n_fail++; $display("FAIL ooo_drained: commit=%b want 0", commit);
    end
  endtask

  // head=tail=4 on entry; 15 allocations wrap the tail through 15->0 and stop at 3.
  task automatic test_full_wrap();
    for (int i = 1; i <= 15; i++) begin
      set_issue(2'd0, 5'd9, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      if (i == 12) begin
        n_cmp++;
        if (issue_rob_pos !== 4'd0) begin
          n_fail++; $display("FAIL tail_wrap: got %0d want 0", issue_rob_pos);
        end
      end
      if (i == 14) begin
        n_cmp++;
        if (full !== 1'b0) begin
          n_fail++; $display("FAIL full_at_14: got %b want 0", full);
        end
      end
    end
    n_cmp++;
    if ({full, issue_rob_pos} !== {1'b1, 4'd3}) begin
      n_fail++; $display("FAIL full_at_15: got full=%b pos=%0d want 1/3", full, issue_rob_pos);
    end
    tick();
    clr_inputs();
    n_cmp++;
    if (issue_rob_pos !== 4'd3) begin
      n_fail++; $display("FAIL issue_when_full: tail=%0d want 3", issue_rob_pos);
    end
    alu_valid = 1'b1; alu_rob_pos = 4'd4; alu_val = 32'h44;
    tick();
    clr_inputs();
    tick();
    n_cmp++;
    if ({full, commit, commit_rob_pos} !== {1'b0, 1'b1, 4'd4}) begin
      n_fail++; $display("FAIL full_release: got full=%b c=%b pos=%0d want 0/1/4",
                         full, commit, commit_rob_pos);
    end
  endtask

  task automatic test_rdy_and_reset();
    rdy = 1'b0;
    alu_valid = 1'b1; alu_rob_pos = 4'd5; alu_val = 32'h55;
    set_issue(2'd0, 5'd1, 32'h0, 1'b0, 1'b1, 32'h0);
    tick();
    rdy = 1'b1;
    clr_inputs();
    tick();
    n_cmp++;
    if ({commit, issue_rob_pos} !== {1'b0, 4'd3}) begin
      n_fail++; $display("FAIL rdy_low_hold: got c=%b tail=%0d want 0/3", commit, issue_rob_pos);
    end
    alu_valid = 1'b1; alu_rob_pos = 4'd5; alu_val = 32'h55;
    tick();
    clr_inputs();
    tick();
    n_cmp++;
    if ({commit, commit_rob_pos, commit_val} !== {1'b1, 4'd5, 32'h55}) begin
      n_fail++; $display("FAIL commit_before_rst: got c=%b pos=%0d val=%h want 1/5/55",
                         commit, commit_rob_pos, commit_val);
    end
    #2;
    rdy = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({commit, commit_val, full, issue_rob_pos, halt} !== {1'b0, 32'd0, 1'b0, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL async_reset: got c=%b v=%h f=%b pos=%0d h=%b want all 0",
                         commit, commit_val, full, issue_rob_pos, halt);
    end
    #1;
    rst = 1'b0;
    rdy = 1'b1;
    set_issue(2'd0, 5'd7, 32'h0, 1'b0, 1'b1, 32'hAB);
    tick();
    clr_inputs();
    tick();
    n_cmp++;
    if ({commit, commit_rob_pos, commit_rd, commit_val} !== {1'b1, 4'd0, 5'd7, 32'hAB}) begin
      n_fail++; $display("FAIL issue_after_reset: got c=%b pos=%0d rd=%0d val=%h want 1/0/7/ab",
                         commit, commit_rob_pos, commit_rd, commit_val);
    end
  endtask

  // head=tail=1 on entry.
  task automatic test_branch();
    set_issue(2'd1, 5'd0, 32'h100, 1'b0, 1'b0, 32'h0);
    tick();
    set_issue(2'd0, 5'd3, 32'h104, 1'b0, 1'b0, 32'h0);
    tick();
    clr_inputs();
    alu_valid = 1'b1; alu_rob_pos = 4'd1; alu_jmp = 1'b1; alu_target = 32'h200;
    tick();
    clr_inputs();
    set_issue(2'd0, 5'd4, 32'h108, 1'b0, 1'b1, 32'h0);
    tick();
    clr_inputs();
    n_cmp++;
    if ({rollback, redirect_pc, issue_rob_pos} !== {1'b1, 32'h200, 4'd0}) begin
      n_fail++; $display("FAIL rollback_taken: got rb=%b pc=%h tail=%0d want 1/200/0",
                         rollback, redirect_pc, issue_rob_pos);
    end
    alu_valid = 1'b1; alu_rob_pos = 4'd2; alu_val = 32'h99;
    tick();
    clr_inputs();
    n_cmp++;
    if ({rollback, redirect_pc} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL rollback_pulse: got rb=%b pc=%h want 0/0", rollback, redirect_pc);
    end
    tick();
    n_cmp++;
    if ({commit, issue_rob_pos} !== {1'b0, 4'd0}) begin
      n_fail++; $display("FAIL flushed_entry: got c=%b tail=%0d want 0/0", commit, issue_rob_pos);
    end
    // Correctly predicted taken branch at pos0: no pulses.
    set_issue(2'd1, 5'd0, 32'h300, 1'b1, 1'b0, 32'h0);
    tick();
    clr_inputs();
    alu_valid = 1'b1; alu_rob_pos = 4'd0; alu_jmp = 1'b1; alu_target = 32'h400;
    tick();
    clr_inputs();
    tick();
    n_cmp++;
    if ({rollback, commit, issue_rob_pos} !== {1'b0, 1'b0, 4'd1}) begin
      n_fail++; $display("FAIL branch_correct: got rb=%b c=%b tail=%0d want 0/0/1",
                         rollback, commit, issue_rob_pos);
    end
    // Predicted taken, actually not taken: redirect to pc+4.
    set_issue(2'd1, 5'd0, 32'h500, 1'b1, 1'b0, 32'h0);
    tick();
    clr_inputs();
    alu_valid = 1'b1; alu_rob_pos = 4'd1; alu_jmp = 1'b0; alu_target = 32'h900;
    tick();
    clr_inputs();
    tick();
    n_cmp++;
    if ({rollback, redirect_pc} !== {1'b1, 32'h504}) begin
      n_fail++; $display("FAIL rollback_not_taken: got rb=%b pc=%h want 1/504",
                         rollback, redirect_pc);
    end
    tick();
  endtask

  // ROB is empty at pos0 after the last rollback.
  task automatic test_store_exit();
    set_issue(2'd2, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0);
    tick();
    clr_inputs();
    tick();
    n_cmp++;
    if ({store_commit, store_rob_pos, commit} !== {1'b1, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL store_commit: got s=%b pos=%0d c=%b want 1/0/0",
                         store_commit, store_rob_pos, commit);
    end
    set_issue(2'd3, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0);
    tick();
    clr_inputs();
    tick();
    n_cmp++;
    if ({halt, store_commit} !== {1'b1, 1'b0}) begin
      n_fail++; $display("FAIL exit_halt: got h=%b s=%b want 1/0", halt, store_commit);
    end
    set_issue(2'd0, 5'd2, 32'h0, 1'b0, 1'b1, 32'h5);
    tick();
    clr_inputs();
    tick();
    tick();
    n_cmp++;
    if ({halt, commit} !== {1'b1, 1'b0}) begin
      n_fail++; $display("FAIL halt_sticky: got h=%b c=%b want 1/0", halt, commit);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_commit_reg();
    test_query_fwd();
    test_out_of_order();
    test_full_wrap();
    test_rdy_and_reset();
    test_branch();
    test_store_exit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
